// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell is reused for every bit,
// LSB first, with the carry held in a flop between cycles.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic              msb_cin_q, msb_cin_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fa_sum, fa_cout;

    full_adder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_sum),
        .co (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    res_d     = '0;
                    carry_d   = 1'b0;
                    msb_cin_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    res_d   = {fa_sum, res_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    if (cnt_q == LAST) begin
                        // carry entering the MSB is kept for the overflow flag
                        msb_cin_d = carry_q;
                        cnt_d     = '0;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cnt_q     <= cnt_d;
        end
    end

    // flags are only meaningful once the last bit is in, so they read 0 otherwise
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;
    assign cout      = out_valid & carry_q;
    assign overflow  = out_valid & (msb_cin_q ^ carry_q);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: transaction-level reference model,
// per-cycle compare process, directed literal cases and a randomized sweep.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready, out_valid, cout, overflow, busy;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result held.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic         m_c = 1'b0;
    logic         m_o = 1'b0;
    bit           m_zero = 1'b1;
    logic [W:0]   m_s;
    logic [W-1:0] m_bb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_zero  = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_bb    = sub ? ~op_b : op_b;
                    m_s     = {1'b0, op_a} + {1'b0, m_bb} + {{W{1'b0}}, (sub | cin)};
                    m_res   = m_s[W-1:0];
                    m_c     = m_s[W];
                    m_o     = (op_a[W-1] == m_bb[W-1]) && (m_s[W-1] != op_a[W-1]);
                    m_left  = W;
                    m_phase = 1;
                    m_zero  = 1'b0;
                end
                1: if (abort) begin
                    m_phase = 0;
                    m_zero  = 1'b1;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2) begin
                chk("result", result, m_res);
                chk("cout", cout, m_c);
                chk("overflow", overflow, m_o);
            end else if (m_phase == 0 && m_zero) begin
                chk("idle_result_zero", result, 0);
                chk("idle_cout_zero", cout, 0);
                chk("idle_ovf_zero", overflow, 0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("issue_timeout", in_ready, 1);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (out_valid === 1'b1) chk("latency", cyc - acc_cyc, W);
        else chk("done_timeout", out_valid, 1);
    endtask

    task automatic handshake(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_op(input string name, input logic [W-1:0] er, input logic ec, input logic eo);
        wait_done();
        chk({name, "_result"}, result, er);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, overflow, eo);
        handshake(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0, 1'b0); expect_op("add_5a_3c", 8'h96, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1'b0); expect_op("add_ff_01", 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 1'b0); expect_op("add_cin", 8'h01, 1'b0, 1'b0);
        issue(8'h10, 8'h20, 1'b1, 1'b1); expect_op("sub_10_20", 8'hF0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b1); expect_op("sub_80_01", 8'h7F, 1'b1, 1'b1);

        // backpressure with a pending request that must not be taken
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        wait_done();
        in_valid = 1'b1;
        repeat (5) begin
            op_a = W'($urandom_range(0, 255));
            op_b = W'($urandom_range(0, 255));
            @(negedge clk);
            chk("bp_result", result, 8'h77);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        op_a = 8'h01; op_b = 8'h01; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_back_idle", in_ready, 1);
        chk("bp_valid_low", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc = cyc;
        chk("bp_accepted", busy, 1);
        expect_op("bp_next", 8'h02, 1'b0, 1'b0);

        // abort while bit 3 is being computed
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        repeat (12) @(negedge clk);

        // abort coinciding with the final bit
        issue(8'h7F, 8'h7F, 1'b1, 1'b0);
        repeat (W - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_last_out_valid", out_valid, 0);
        chk("abort_last_in_ready", in_ready, 1);
        chk("abort_last_result", result, 0);
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of bit 5
        issue(8'h55, 8'h0F, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, 1'b0); expect_op("post_rst", 8'h02, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done();
            handshake($urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
